cp0_unit: RTL

//  W-stage coprocessor-0. Consumes ExcCodeW from the M-stage exception checker plus the PC/BD of the

---
 rtl/cp0_defs.sv | 35 +++
 rtl/cp0_timer.sv | 45 ++++
 rtl/cp0_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cp0_defs.sv
// Shared CP0 definitions: register numbers, ExcCode values and SR/Cause field positions.
// Used by the W-stage cp0_unit and its optional cp0_timer.
package cp0_defs;

  typedef enum logic [4:0] {
    REG_COUNT   = 5'd9,
    REG_COMPARE = 5'd11,
    REG_SR      = 5'd12,
    REG_CAUSE   = 5'd13,
    REG_EPC     = 5'd14,
    REG_PRID    = 5'd15
  } cp0_reg_e;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count ticks every cycle, TI sets (sticky) when Count hits Compare after a tick.
// Loading Count suppresses that cycle's tick; writing Compare clears TI.
module cp0_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    count_d   = count_we ? wdata : count_q + 32'd1;
    compare_d = compare_we ? wdata : compare_q;
    ti_d      = ti_q;
    if (compare_we) begin
      ti_d = 1'b0;
    end else if (!count_we && (count_d == compare_q)) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// W-stage CP0 (SR/Cause/EPC/PRId): combinational flush req, state updates on the next edge, no backpressure.
// Optional Count/Compare timer under CP0_COUNT_EN.
module cp0_unit
  import cp0_defs::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h2024_1127
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        instr_valid,
  input  logic [5:0]  hw_int,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] wdata,
  input  logic        eret,
  output logic [31:0] rdata,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [5:0]  ip_q, ip_next;
  logic [31:0] epc_q, epc_d;
  logic        ti, int_req, exc_req, wr_en;
  logic [31:0] sr_rd, cause_rd;

`ifdef CP0_COUNT_EN
  logic [31:0] count, compare;

  cp0_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .count_we   (wr_en && (cp0_addr == REG_COUNT)),
    .compare_we (wr_en && (cp0_addr == REG_COMPARE)),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  assign ti = 1'b0;
`endif

  // Interrupt decision uses the IP value being latched this cycle, so no sampling delay.
  assign ip_next = {hw_int[5] | ti, hw_int[4:0]};
  assign int_req = (|(ip_next & im_q)) & ie_q & ~exl_q;
  assign exc_req = instr_valid & (exc_code != EXC_INT) & ~exl_q;
  assign req     = int_req | exc_req;
  assign wr_en   = we & ~req;

  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    if (req) begin
      exl_d     = 1'b1;
      exccode_d = int_req ? 5'(EXC_INT) : exc_code;
      bd_d      = exc_bd;
      epc_d     = (exc_bd ? exc_pc - 32'd4 : exc_pc) & ~32'h3;
    end else begin
      if (we && (cp0_addr == REG_SR)) begin
        im_d  = wdata[SR_IM_HI:SR_IM_LO];
        exl_d = wdata[SR_EXL];
        ie_d  = wdata[SR_IE];
      end
      if (we && (cp0_addr == REG_EPC)) begin
        epc_d = wdata & ~32'h3;
      end
      // eret's EXL clear overrides a simultaneous SR write.
      if (eret) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      exccode_q <= '0;
      ip_q      <= '0;
      epc_q     <= '0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      exccode_q <= exccode_d;
      ip_q      <= ip_next;
      epc_q     <= epc_d;
    end
  end

  always_comb begin
    sr_rd                           = '0;
    sr_rd[SR_IE]                    = ie_q;
    sr_rd[SR_EXL]                   = exl_q;
    sr_rd[SR_IM_HI:SR_IM_LO]        = im_q;
    cause_rd                        = '0;
    cause_rd[CAUSE_BD]              = bd_q;
    cause_rd[CAUSE_TI]              = ti;
    cause_rd[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_q;
    cause_rd[CAUSE_EXC_HI:CAUSE_EXC_LO] = exccode_q;
  end

  always_comb begin
    rdata = '0;
    case (cp0_addr)
      REG_SR:      rdata = sr_rd;
      REG_CAUSE:   rdata = cause_rd;
      REG_EPC:     rdata = epc_q;
      REG_PRID:    rdata = PRID_VAL;
`ifdef CP0_COUNT_EN
      REG_COUNT:   rdata = count;
      REG_COMPARE: rdata = compare;
`endif
      default:     rdata = '0;
    endcase
  end

  assign epc_out    = epc_q;
  assign handler_pc = HANDLER_ADDR;

endmodule
